// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM DMA arbiter: sequencer states, fixed addresses
// and the four-phase bus cycle numbering also used by the CPU bus FSM.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] ADDR_DMA = 16'hFF46;
    localparam logic [15:0] ADDR_OAM = 16'hFE00;
    localparam int          OAM_LEN  = 160;

    localparam logic [1:0] PH_T1 = 2'd0;
    localparam logic [1:0] PH_T2 = 2'd1;
    localparam logic [1:0] PH_T3 = 2'd2;
    localparam logic [1:0] PH_T4 = 2'd3;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        rd;
        logic        wr;
    } bus_req_t;

endpackage

// File: rtl/oam_dma_arbiter_dma_seq.sv
// OAM DMA sequencer: walks the source page byte by byte, one read cycle and one
// write cycle per byte, and presents the resulting bus request to the arbiter.
module dma_seq
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DST_BASE = ADDR_OAM,
    parameter int          LEN      = OAM_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic [7:0] trigger_src,
    input  logic [7:0] bus_din,
    output logic [7:0] src,
    output logic       busy,
    output logic       active,
    output bus_req_t   req
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t state, state_next;
    logic [1:0] ph;
    logic [7:0] idx;
    logic [7:0] data_buf;

    assign busy = (state != IDLE);

    // A trigger restarts the copy from any state, including mid-transfer.
    always_comb begin
        state_next = state;
        if (trigger) begin
            state_next = START;
        end else if (ph == PH_T4) begin
            case (state)
                START:   state_next = READ;
                READ:    state_next = WRITE;
                WRITE:   state_next = (idx == LAST_IDX) ? IDLE : READ;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= PH_T1;
            idx      <= 8'h00;
            src      <= 8'h00;
            data_buf <= 8'h00;
            active   <= 1'b0;
        end else begin
            state  <= state_next;
            active <= (state_next != IDLE);
            if (trigger) begin
                src <= trigger_src;
                idx <= 8'h00;
                ph  <= PH_T1;
            end else if (state != IDLE) begin
                ph <= ph + 2'd1;
                if (state == READ && ph == PH_T4) begin
                    data_buf <= bus_din;
                end
                if (state == WRITE && ph == PH_T4 && idx != LAST_IDX) begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

    // Strobes are masked during reset so an interrupted write never reaches OAM.
    always_comb begin
        req = '0;
        case (state)
            START: begin
                req.a = {src, idx};
            end
            READ: begin
                req.a  = {src, idx};
                req.rd = (ph != PH_T4);
            end
            WRITE: begin
                req.a    = DST_BASE + {8'h00, idx};
                req.dout = data_buf;
                req.wr   = (ph == PH_T4);
            end
            default: begin
                req = '0;
            end
        endcase
        if (!rst_n) begin
            req.rd = 1'b0;
            req.wr = 1'b0;
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU/DMA bus arbiter: passes CPU cycles through when idle, hands the bus to the
// OAM DMA sequencer while a copy runs, and decodes the DMA source register.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = ADDR_DMA,
    parameter logic [15:0] DMA_DST_BASE = ADDR_OAM,
    parameter int          DMA_LEN      = OAM_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        dma_active
);

    logic     cpu_wr_q;
    logic     dma_hit;
    logic     trigger;
    logic     busy;
    logic [7:0] src;
    bus_req_t req;

    assign dma_hit = (cpu_a == DMA_REG_ADDR);
    assign trigger = cpu_wr && dma_hit && !cpu_wr_q;

    // Edge detect so a write strobe held over several clocks starts one copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_wr_q <= 1'b0;
        end else begin
            cpu_wr_q <= cpu_wr;
        end
    end

    dma_seq #(
        .DST_BASE (DMA_DST_BASE),
        .LEN      (DMA_LEN)
    ) u_dma_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger     (trigger),
        .trigger_src (cpu_dout),
        .bus_din     (bus_din),
        .src         (src),
        .busy        (busy),
        .active      (dma_active),
        .req         (req)
    );

    // The DMA register is local: its accesses never appear on the system bus.
    always_comb begin
        bus_a    = cpu_a;
        bus_dout = cpu_dout;
        bus_rd   = cpu_rd && !dma_hit;
        bus_wr   = cpu_wr && !dma_hit;
        cpu_din  = bus_din;
        if (busy) begin
            bus_a    = req.a;
            bus_dout = req.dout;
            bus_rd   = req.rd;
            bus_wr   = req.wr;
            cpu_din  = 8'hFF;
        end
        if (dma_hit && cpu_rd) begin
            cpu_din = src;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: table vectors for pass-through plus
// randomized CPU traffic against a transfer-timeline reference model.
`timescale 1ns/1ps
module tb_oam_dma_arbiter;
    import oam_dma_arbiter_pkg::*;

    localparam int XFER_CYCLES = 4 + 8 * OAM_LEN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_rd;
    logic        bus_wr;
    logic        dma_active;

    logic        use_mem;
    logic [7:0]  din_drive;

    int n_vec = 0;
    int n_err = 0;
    int act_cnt = 0;

    // Reference model: cycles since the last accepted trigger (0 = none yet).
    int          m_k;
    logic [7:0]  m_src;
    logic        m_prev;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        rd;
        logic        wr;
        logic [7:0]  din;
        logic [15:0] exp_a;
        logic [7:0]  exp_dout;
        logic        exp_rd;
        logic        exp_wr;
        logic [7:0]  exp_cpu_din;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'hA5;
    endfunction

    assign bus_din = use_mem ? mem_byte(bus_a) : din_drive;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_a      (cpu_a),
        .cpu_dout   (cpu_dout),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_din    (cpu_din),
        .bus_a      (bus_a),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .dma_active (dma_active)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input logic rd, input logic wr, input logic rn);
        cpu_a    = a;
        cpu_dout = d;
        cpu_rd   = rd;
        cpu_wr   = wr;
        rst_n    = rn;
    endtask

    // Update the model with the inputs seen at this edge, then step past it.
    task automatic advance();
        if (!rst_n) begin
            m_k    = 0;
            m_src  = 8'h00;
            m_prev = 1'b0;
        end else begin
            if (cpu_wr && cpu_a == ADDR_DMA && !m_prev) begin
                m_src = cpu_dout;
                m_k   = 1;
            end else if (m_k != 0 && m_k <= XFER_CYCLES) begin
                m_k++;
            end
            m_prev = cpu_wr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doCycle(input logic [15:0] a, input logic [7:0] d,
                           input logic rd, input logic wr, input logic rn);
        logic        e_act, e_rd, e_wr, ma, md;
        logic [15:0] e_a;
        logic [7:0]  e_d, e_cpu;
        int          j, b, p;
        applyStimulus(a, d, rd, wr, rn);
        @(negedge clk);
        if (m_k >= 1 && m_k <= XFER_CYCLES) begin
            e_act = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
            ma = 1'b0; md = 1'b0; e_a = 16'h0; e_d = 8'h0;
            if (m_k > 4) begin
                j = m_k - 5;
                b = j / 8;
                p = j % 8;
                ma = 1'b1;
                if (p < 4) begin
                    e_a  = {m_src, b[7:0]};
                    e_rd = (p < 3);
                end else begin
                    md   = 1'b1;
                    e_a  = ADDR_OAM + 16'(b);
                    e_d  = mem_byte({m_src, b[7:0]});
                    e_wr = (p == 7);
                end
            end
            if (!rn) begin
                e_rd = 1'b0;
                e_wr = 1'b0;
            end
            e_cpu = (rd && a == ADDR_DMA) ? m_src : 8'hFF;
        end else begin
            e_act = 1'b0; ma = 1'b1; md = 1'b1;
            e_a   = a;
            e_d   = d;
            e_rd  = rd && (a != ADDR_DMA);
            e_wr  = wr && (a != ADDR_DMA);
            e_cpu = (rd && a == ADDR_DMA) ? m_src : mem_byte(a);
        end
        checkOutput($sformatf("bus k=%0d", m_k),
                    64'({dma_active, bus_rd, bus_wr, (ma ? bus_a : 16'h0), (md ? bus_dout : 8'h0)}),
                    64'({e_act, e_rd, e_wr, e_a, e_d}));
        checkOutput($sformatf("cpu_din k=%0d a=%h", m_k, a), 64'(cpu_din), 64'(e_cpu));
        if (dma_active) act_cnt++;
        advance();
    endtask

    task automatic randomCycle();
        logic [15:0] a;
        logic        rd, wr;
        int          kind;
        case ($urandom_range(0, 3))
            0:       a = 16'h8000;
            1:       a = 16'hD000;
            2:       a = ADDR_DMA;
            default: a = 16'($urandom);
        endcase
        kind = $urandom_range(0, 2);
        rd   = (kind == 1);
        wr   = (kind == 2);
        if (a == ADDR_DMA) wr = 1'b0;
        doCycle(a, (a == 16'hD000) ? 8'hAA : 8'($urandom), rd, wr, 1'b1);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) randomCycle();
    endtask

    task automatic triggerDma(input logic [7:0] s);
        doCycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        doCycle(ADDR_DMA, s, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{16'hC000, 8'h00, 1'b1, 1'b0, 8'h5A, 16'hC000, 8'h00, 1'b1, 1'b0, 8'h5A};
        vecs[1] = '{16'h8000, 8'h11, 1'b0, 1'b1, 8'h00, 16'h8000, 8'h11, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 8'h33, 16'hFF46, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{16'h1234, 8'h9C, 1'b0, 1'b0, 8'h77, 16'h1234, 8'h9C, 1'b0, 1'b0, 8'h77};
        vecs[4] = '{16'hFFFF, 8'h00, 1'b1, 1'b0, 8'hC3, 16'hFFFF, 8'h00, 1'b1, 1'b0, 8'hC3};
        vecs[5] = '{16'hFE9F, 8'h42, 1'b0, 1'b1, 8'h00, 16'hFE9F, 8'h42, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{16'hFF47, 8'h00, 1'b1, 1'b0, 8'h81, 16'hFF47, 8'h00, 1'b1, 1'b0, 8'h81};
        vecs[7] = '{16'h0000, 8'hFF, 1'b0, 1'b1, 8'h18, 16'h0000, 8'hFF, 1'b0, 1'b1, 8'h18};

        use_mem = 1'b1; din_drive = 8'h00;
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        m_k = 0; m_src = 8'h00; m_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        doCycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        doCycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("[TB] idle pass-through table");
        use_mem = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din_drive = vecs[i].din;
            applyStimulus(vecs[i].a, vecs[i].dout, vecs[i].rd, vecs[i].wr, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i),
                        64'({bus_a, bus_dout, bus_rd, bus_wr, cpu_din, dma_active}),
                        64'({vecs[i].exp_a, vecs[i].exp_dout, vecs[i].exp_rd,
                             vecs[i].exp_wr, vecs[i].exp_cpu_din, 1'b0}));
            advance();
        end
        use_mem = 1'b1;

        $display("[TB] random idle traffic");
        runCycles(200);

        $display("[TB] full transfer from C100");
        triggerDma(8'hC1);
        act_cnt = 0;
        runCycles(XFER_CYCLES + 6);
        checkOutput("active_len_c1", 64'(act_cnt), 64'(XFER_CYCLES));

        $display("[TB] retrigger with 80 at byte 50");
        triggerDma(8'hC1);
        runCycles(405);
        triggerDma(8'h80);
        act_cnt = 0;
        runCycles(XFER_CYCLES + 6);
        checkOutput("active_len_retrig", 64'(act_cnt), 64'(XFER_CYCLES));

        $display("[TB] reset during final phase of byte 100 write");
        triggerDma(8'hC1);
        runCycles(811);
        doCycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        doCycle(ADDR_DMA, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("src_after_reset", 64'(cpu_din), 64'(8'h00));

        $display("[TB] held write to DMA register");
        doCycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        act_cnt = 0;
        repeat (4) doCycle(ADDR_DMA, 8'h22, 1'b0, 1'b1, 1'b1);
        runCycles(XFER_CYCLES);
        checkOutput("active_len_held", 64'(act_cnt), 64'(XFER_CYCLES));

        $display("[TB] random source page");
        triggerDma(8'($urandom));
        act_cnt = 0;
        runCycles(XFER_CYCLES + 6);
        checkOutput("active_len_rand", 64'(act_cnt), 64'(XFER_CYCLES));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
